// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer (fetch, decode, exec, load/store/branch/system/trap).
// Define CPU_CTRL_ALU_WAIT_EN to stall EXEC while I_alu_busy is high.
module cpu_ctrl (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic [2:0] I_next_stage,
   input  logic       I_wb_from_alu,
   input  logic       I_wb_from_imm,
   input  logic       I_next_pc_from_alu,
   input  logic       I_branch_taken,
   input  logic       I_alu_busy,
   input  logic       I_sys_done,
   input  logic       I_bus_ack,
   input  logic       I_bus_err,
   output logic [3:0] O_state,
   output logic       O_bus_req,
   output logic       O_bus_we,
   output logic       O_bus_addr_sel,
   output logic       O_ir_we,
   output logic       O_dec_en,
   output logic       O_reg_we,
   output logic [1:0] O_reg_sel,
   output logic       O_pc_we,
   output logic [1:0] O_pc_sel,
   output logic       O_trap,
   output logic       O_instret
);
   localparam logic [2:0] EXEC_TO_FETCH  = 3'd0;
   localparam logic [2:0] EXEC_TO_LOAD   = 3'd1;
   localparam logic [2:0] EXEC_TO_STORE  = 3'd2;
   localparam logic [2:0] EXEC_TO_BRANCH = 3'd3;
   localparam logic [2:0] EXEC_TO_SYSTEM = 3'd4;
   localparam logic [2:0] EXEC_TO_TRAP   = 3'd5;
   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_LOAD   = 4'd4,
      S_STORE  = 4'd5,
      S_BRANCH = 4'd6,
      S_SYSTEM = 4'd7,
      S_TRAP   = 4'd8
   } state_t;
   state_t state, state_nx;
   logic   wb_pending, wb_pending_nx, wb_sel, wb_sel_nx, alu_wait;
`ifdef CPU_CTRL_ALU_WAIT_EN
   assign alu_wait = I_alu_busy;
`else
   logic unused_alu_busy;
   assign unused_alu_busy = I_alu_busy;
   assign alu_wait = 1'b0;
`endif
   assign O_state = state;
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state      <= S_RESET;
         wb_pending <= 1'b0;
         wb_sel     <= 1'b0;
      end else begin
         state      <= state_nx;
         wb_pending <= wb_pending_nx;
         wb_sel     <= wb_sel_nx;
      end
   end
   always_comb begin
      state_nx       = state;
      wb_pending_nx  = wb_pending;
      wb_sel_nx      = wb_sel;
      O_bus_req      = 1'b0;
      O_bus_we       = 1'b0;
      O_bus_addr_sel = 1'b0;
      O_ir_we        = 1'b0;
      O_dec_en       = 1'b0;
      O_reg_we       = 1'b0;
      O_reg_sel      = 2'd0;
      O_pc_we        = 1'b0;
      O_pc_sel       = 2'd0;
      O_trap         = 1'b0;
      O_instret      = 1'b0;
      case (state)
         S_RESET: state_nx = S_FETCH;
         S_FETCH: begin
            O_bus_req = 1'b1;
            // deferred ALU/IMM write of the previous instruction; pending only lives for one FETCH cycle
            O_reg_we      = wb_pending & ~I_bus_err;
            O_reg_sel     = wb_pending ? {1'b0, wb_sel} : 2'd0;
            wb_pending_nx = 1'b0;
            if (I_bus_err) state_nx = S_TRAP;
            else if (I_bus_ack) begin
               O_ir_we  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            O_dec_en = 1'b1;
            state_nx = S_EXEC;
         end
         S_EXEC: if (!alu_wait) case (I_next_stage)
            EXEC_TO_FETCH: begin
               O_pc_we       = 1'b1;
               O_pc_sel      = I_next_pc_from_alu ? 2'd1 : 2'd0;
               O_instret     = 1'b1;
               wb_pending_nx = I_wb_from_alu | I_wb_from_imm;
               wb_sel_nx     = I_wb_from_imm;
               state_nx      = S_FETCH;
            end
            EXEC_TO_LOAD:   state_nx = S_LOAD;
            EXEC_TO_STORE:  state_nx = S_STORE;
            EXEC_TO_BRANCH: state_nx = S_BRANCH;
            EXEC_TO_SYSTEM: state_nx = S_SYSTEM;
            EXEC_TO_TRAP:   state_nx = S_TRAP;
            default:        state_nx = S_TRAP;
         endcase
         S_LOAD: begin
            O_bus_req      = 1'b1;
            O_bus_addr_sel = 1'b1;
            if (I_bus_err) state_nx = S_TRAP;
            else if (I_bus_ack) begin
               O_reg_we  = 1'b1;
               O_reg_sel = 2'd2;
               O_pc_we   = 1'b1;
               O_instret = 1'b1;
               state_nx  = S_FETCH;
            end
         end
         S_STORE: begin
            O_bus_req      = 1'b1;
            O_bus_we       = 1'b1;
            O_bus_addr_sel = 1'b1;
            if (I_bus_err) state_nx = S_TRAP;
            else if (I_bus_ack) begin
               O_pc_we   = 1'b1;
               O_instret = 1'b1;
               state_nx  = S_FETCH;
            end
         end
         S_BRANCH: begin
            O_pc_we   = 1'b1;
            O_pc_sel  = I_branch_taken ? 2'd2 : 2'd0;
            O_instret = 1'b1;
            state_nx  = S_FETCH;
         end
         S_SYSTEM: if (I_sys_done) begin
            O_pc_we   = 1'b1;
            O_instret = 1'b1;
            state_nx  = S_FETCH;
         end
         S_TRAP: begin
            O_trap        = 1'b1;
            O_pc_we       = 1'b1;
            O_pc_sel      = 2'd3;
            wb_pending_nx = 1'b0;
            state_nx      = S_FETCH;
         end
         default: state_nx = S_RESET;
      endcase
   end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle sequencer for the CPU core. It walks each instruction through fetch, decode, execute and the memory, branch, system or trap stage selected by the decoder's `exec_next_stage`. It drives the bus request, instruction-register latch, decoder enable, register-file write and PC update strobes. It sits between the decoder, ALU, register file, PC register and the memory bus port.

## Interface
Parameters:
- none

Ports:
- I_clk  in  1  core clock
- I_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- I_next_stage  in  3  decoder stage select, `EXEC_TO_*` encoding from cpudefs.vh
- I_wb_from_alu  in  1  decoder: write ALU result to rd
- I_wb_from_imm  in  1  decoder: write immediate to rd
- I_next_pc_from_alu  in  1  decoder: next PC is the ALU result (JAL/JALR)
- I_branch_taken  in  1  branch comparator result, valid in BRANCH
- I_alu_busy  in  1  multi-cycle ALU op in progress
- I_sys_done  in  1  system unit finished
- I_bus_ack  in  1  bus transfer complete
- I_bus_err  in  1  bus transfer failed
- O_state  out  4  current state (debug)
- O_bus_req  out  1  bus request
- O_bus_we  out  1  bus write
- O_bus_addr_sel  out  1  bus address source: 0 = PC, 1 = ALU result
- O_ir_we  out  1  latch instruction register
- O_dec_en  out  1  decoder enable
- O_reg_we  out  1  register-file write
- O_reg_sel  out  2  write data source: 0 = ALU, 1 = IMM, 2 = MEM
- O_pc_we  out  1  PC write
- O_pc_sel  out  2  next PC: 0 = PC+4, 1 = ALU, 2 = branch target, 3 = trap vector
- O_trap  out  1  trap entry pulse
- O_instret  out  1  instruction retired pulse

## Operation
- States and O_state codes:
  - RESET = 0, FETCH = 1, DECODE = 2, EXEC = 3, LOAD = 4
  - STORE = 5, BRANCH = 6, SYSTEM = 7, TRAP = 8
- All outputs are combinational decodes of the state, the inputs and the internal flags wb_pending and wb_sel.
- RESET: all outputs 0. Moves to FETCH unconditionally.
- FETCH:
  - bus_req = 1, addr_sel = 0, we = 0.
  - On the first FETCH cycle only, if wb_pending: reg_we = 1, reg_sel = wb_sel. wb_pending is then cleared.
  - On bus_ack without bus_err: ir_we = 1, go to DECODE.
- DECODE: dec_en = 1 for one cycle, then EXEC.
- EXEC dispatches on I_next_stage:
  - FETCH: pc_we = 1, pc_sel = ALU if next_pc_from_alu, else PC+4; instret = 1. Set wb_pending = wb_from_alu | wb_from_imm and wb_sel = IMM if wb_from_imm, else ALU.
  - LOAD, STORE, BRANCH, SYSTEM: go to the state of the same name.
  - TRAP or any unknown code: go to TRAP.
- LOAD:
  - bus_req = 1, addr_sel = 1, we = 0.
  - On ack: reg_we = 1, reg_sel = MEM, pc_we = 1, pc_sel = PC+4, instret = 1, go to FETCH.
- STORE:
  - bus_req = 1, addr_sel = 1, we = 1.
  - On ack: pc_we = 1, pc_sel = PC+4, instret = 1, go to FETCH.
- BRANCH: one cycle. pc_we = 1, pc_sel = branch target if I_branch_taken, else PC+4; instret = 1; go to FETCH.
- SYSTEM: hold until sys_done, then pc_we = 1, pc_sel = PC+4, instret = 1, go to FETCH.
- TRAP: trap = 1, pc_we = 1, pc_sel = trap vector, instret = 0, go to FETCH. wb_pending is cleared.
- Bus error: bus_err in FETCH, LOAD or STORE goes to TRAP, with no ir_we, reg_we or instret. If err and ack arrive in the same cycle, err wins.

## Timing
- Bus ack may arrive in the same cycle as req; bus_req holds high until ack or err.
- Minimum cycles per instruction with zero-wait memory:
  - 3: OP, OPIMM, LUI, AUIPC, JAL/JALR, MISCMEM
  - 4: load, store, branch
  - 4 or more: system, gated by sys_done
- The register write for ALU/IMM results lands in the next instruction's first FETCH cycle. It never coincides with a LOAD write.
- Async reset mid-operation: state returns to RESET immediately, wb_pending is cleared, and all outputs drop to 0 combinationally.

## Configuration
- CPU_CTRL_ALU_WAIT_EN defined: EXEC holds while I_alu_busy = 1, with no strobes asserted. It dispatches in the first cycle with busy = 0.
- Undefined: I_alu_busy is ignored and EXEC always lasts one cycle.

## Test plan
- ADDI with ack in the req cycle: state sequence 1→2→3→1. pc_we with pc_sel = 0 and instret in EXEC. reg_we with reg_sel = 0 in the next FETCH cycle.
- LW with a 2-cycle ack delay: LOAD holds bus_req, addr_sel = 1, we = 0 for 3 cycles. reg_we with reg_sel = 2 in the ack cycle; total 6 cycles.
- Branch with taken = 1 then taken = 0: pc_sel = 2, then pc_sel = 0; BRANCH lasts 1 cycle each time.
- ack and err together during a STORE: state goes to 8; trap = 1, pc_sel = 3, instret = 0; no reg_we in the following FETCH.
- With CPU_CTRL_ALU_WAIT_EN, alu_busy high for 5 cycles: EXEC lasts 6 cycles. Without the macro, EXEC lasts 1 cycle.
- rst_n asserted mid-LOAD: O_bus_req drops to 0 immediately. After release, state goes 0 then 1, with no reg_we.
